image_bram_reader: RTL and testbench

- Read side of the image BRAM.
- Once the BRAM reports a complete 784-pixel (28x28) image, this block sequences addresses and read requests into the BRAM. It absorbs the BRAM's 1-cycle registered read latency and streams pixels to the input layer over a valid/ready handshake with row/image framing.
- A small output FIFO and credit counter sustain 1 pixel/cycle under backpressure.

---
 rtl/image_bram_reader.sv | 106 ++++++++++
 tb/tb_image_bram_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/image_bram_reader.sv
// image_bram_reader: streams one IMG_W x IMG_H image from BRAM to a valid/ready consumer (optional IMAGE_READER_CHECKSUM_EN adds a pixel checksum)
module image_bram_reader #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mem_read_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic mem_read_request,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] pix_data,
  output logic pix_valid,
  input  logic pix_ready,
  output logic pix_last_col,
  output logic pix_last,
  output logic busy,
  output logic done
`ifdef IMAGE_READER_CHECKSUM_EN
  ,
  output logic [17:0] checksum,
  output logic checksum_valid
`endif
);
  localparam int N = IMG_W * IMG_H;
  localparam int IW = $clog2(N + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  state_t state;
  logic [IW-1:0] issued;
  logic [1:0] in_flight;
  logic req_q;
  logic [DATA_W-1:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic push, pop, accept;
  assign push = req_q;
  assign pix_valid = count != '0;
  assign pop = pix_valid && pix_ready;
  assign accept = state == IDLE && start && mem_read_enable;
  assign mem_read_request = state == STREAM && issued < IW'(N) && mem_read_enable &&
                            (int'(count) + int'(in_flight) < FIFO_DEPTH);
  assign mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(issued);
  assign pix_data = pix_valid ? fifo[rd_ptr] : '0;
  assign pix_last_col = pix_valid && col == CW'(IMG_W - 1);
  assign pix_last = pix_last_col && row == RW'(IMG_H - 1);
  assign busy = state == STREAM || state == DRAIN;
  assign done = state == DONE;
  // FIFO storage: data returned by the BRAM lands here the cycle after its request
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_data;
  end
  // sequencer: state, issue/in-flight credit, FIFO pointers and framing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issued <= '0;
      in_flight <= '0;
      req_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      col <= '0;
      row <= '0;
    end else begin
      req_q <= mem_read_request;
      in_flight <= in_flight + 2'(mem_read_request) - 2'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) begin
        col <= col == CW'(IMG_W - 1) ? '0 : col + 1'b1;
        if (col == CW'(IMG_W - 1)) row <= row == RW'(IMG_H - 1) ? '0 : row + 1'b1;
      end
      if (mem_read_request) issued <= issued + 1'b1;
      case (state)
        IDLE: if (accept) begin
          state <= STREAM;
          issued <= '0;
          col <= '0;
          row <= '0;
        end
        STREAM: if (mem_read_request && issued == IW'(N - 1)) state <= DRAIN;
        DRAIN: if (pop && pix_last) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef IMAGE_READER_CHECKSUM_EN
  assign checksum_valid = done;
  // running sum of accepted pixels, held after the image until the next accepted start
  always_ff @(posedge clk) begin
    if (rst || accept) checksum <= '0;
    else if (pop) checksum <= checksum + 18'(pix_data);
  end
`endif
endmodule

// File: tb/tb_image_bram_reader.sv
// tb_image_bram_reader: directed checks of image streaming, backpressure, framing, pauses and reset
module tb_image_bram_reader;
  localparam int N = 784;
  logic clk = 0, rst = 1, start = 0, ena = 1, pix_ready = 1;
  logic [15:0] mem_addr;
  logic mem_read_request, pix_valid, pix_last_col, pix_last, busy, done;
  logic [7:0] mem_data, pix_data;
  logic [7:0] bram [1024];
`ifdef IMAGE_READER_CHECKSUM_EN
  logic [17:0] checksum;
  logic checksum_valid;
  logic [17:0] cs_at_done;
  logic cv_at_done;
`endif
  image_bram_reader dut (
    .clk(clk), .rst(rst), .start(start), .mem_read_enable(ena),
    .mem_addr(mem_addr), .mem_read_request(mem_read_request), .mem_data(mem_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last_col(pix_last_col), .pix_last(pix_last), .busy(busy), .done(done)
`ifdef IMAGE_READER_CHECKSUM_EN
    , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem_read_request ? bram[mem_addr[9:0]] : 8'hxx;
  typedef struct {int idx; logic [7:0] data; bit lc; bit l;} vec_t;
  vec_t vecs [8];
  int mode = 0;
  bit fill_ff = 0;
  int cyc = 0, t0 = 0, rel;
  int reqs, xfers, first_req_rel, first_valid_rel, last_rel, done_rel, done_cnt;
  int lc_cnt, stab_viol, credit_viol, ena_viol, full_seen;
  logic [15:0] first_addr;
  logic [7:0] cap_d [N];
  bit cap_lc [N], cap_l [N];
  bit prev_stall;
  logic [7:0] pd;
  bit plc, pl;
  int pass = 0, total = 0;
  // per-cycle monitor: drives ready, samples outputs mid-cycle, keeps run statistics
  always @(negedge clk) begin
    cyc++;
    if (rst || (start && !busy)) begin
      t0 = cyc; reqs = 0; xfers = 0; first_req_rel = -1; first_valid_rel = -1;
      last_rel = -1; done_rel = -1; done_cnt = 0; lc_cnt = 0; stab_viol = 0;
      credit_viol = 0; ena_viol = 0; full_seen = 0; prev_stall = 0;
    end
    rel = cyc - t0;
    pix_ready = mode == 0 ? 1'b1 : (rel % 4 == 0 || rel % 4 == 3);
    if (reqs - xfers >= 4) full_seen++;
    if (mem_read_request) begin
      if (reqs == 0) begin first_req_rel = rel; first_addr = mem_addr; end
      if (reqs - xfers >= 4) credit_viol++;
      if (!ena) ena_viol++;
      reqs++;
    end
    if (pix_valid && first_valid_rel < 0) first_valid_rel = rel;
    if (prev_stall && (!pix_valid || pix_data !== pd || pix_last_col !== plc || pix_last !== pl)) stab_viol++;
    if (pix_valid && pix_ready) begin
      if (xfers < N) begin cap_d[xfers] = pix_data; cap_lc[xfers] = pix_last_col; cap_l[xfers] = pix_last; end
      if (pix_last_col) lc_cnt++;
      last_rel = rel;
      xfers++;
    end
    prev_stall = pix_valid && !pix_ready;
    pd = pix_data; plc = pix_last_col; pl = pix_last;
    if (done) begin
      done_cnt++; done_rel = rel;
`ifdef IMAGE_READER_CHECKSUM_EN
      cs_at_done = checksum; cv_at_done = checksum_valid;
`endif
    end
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask
  function automatic int seq_errs();
    int e = 0;
    for (int i = 0; i < N; i++) begin
      logic [7:0] ed = fill_ff ? 8'hFF : 8'(i);
      if (cap_d[i] !== ed || cap_lc[i] !== (i % 28 == 27) || cap_l[i] !== (i == N - 1)) e++;
    end
    return e;
  endfunction
  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("done_pulses", done_cnt, 1);
  endtask
  task automatic wait_xfers(input int n);
    for (int i = 0; i < 4000 && xfers < n; i++) @(posedge clk);
    chk("reach_xfer", xfers >= n, 1);
  endtask
  task automatic check_vectors();
    for (int v = 0; v < 8; v++) begin
      chk($sformatf("vec%0d_data", vecs[v].idx), cap_d[vecs[v].idx], vecs[v].data);
      chk($sformatf("vec%0d_lastcol", vecs[v].idx), cap_lc[vecs[v].idx], vecs[v].lc);
      chk($sformatf("vec%0d_last", vecs[v].idx), cap_l[vecs[v].idx], vecs[v].l);
    end
  endtask
  initial begin
    vecs[0] = '{0, 8'd0, 0, 0};     vecs[1] = '{27, 8'd27, 1, 0};
    vecs[2] = '{28, 8'd28, 0, 0};   vecs[3] = '{55, 8'd55, 1, 0};
    vecs[4] = '{255, 8'd255, 0, 0}; vecs[5] = '{256, 8'd0, 0, 0};
    vecs[6] = '{300, 8'd44, 0, 0};  vecs[7] = '{783, 8'd15, 1, 1};
    for (int i = 0; i < 1024; i++) bram[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", mem_addr, 0);
    chk("rst_req", mem_read_request, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_lastcol", pix_last_col, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    ena = 0;
    pulse_start();
    repeat (6) @(posedge clk);
    #1 chk("noena_busy", busy, 0);
    chk("noena_reqs", reqs, 0);
    ena = 1;
    pulse_start();
    wait_done();
    chk("m0_xfers", xfers, N);
    chk("m0_seq_errs", seq_errs(), 0);
    chk("m0_first_req", first_req_rel, 1);
    chk("m0_first_addr", first_addr, 0);
    chk("m0_first_valid", first_valid_rel, 3);
    chk("m0_last_xfer", last_rel, 786);
    chk("m0_done_cycle", done_rel, 787);
    chk("m0_lastcol_cnt", lc_cnt, 28);
    chk("m0_credit", credit_viol, 0);
    check_vectors();
    mode = 1;
    pulse_start();
    wait_xfers(100);
    pulse_start();
    wait_done();
    chk("m1_xfers", xfers, N);
    chk("m1_seq_errs", seq_errs(), 0);
    chk("m1_stable", stab_viol, 0);
    chk("m1_credit", credit_viol, 0);
    chk("m1_full_seen", full_seen > 0, 1);
    check_vectors();
    mode = 0;
    pulse_start();
    wait_xfers(300);
    @(posedge clk); #1 ena = 0;
    repeat (10) @(posedge clk);
    #1 ena = 1;
    wait_done();
    chk("drop_xfers", xfers, N);
    chk("drop_seq_errs", seq_errs(), 0);
    chk("drop_ena_req", ena_viol, 0);
    chk("drop_late", done_rel > 787, 1);
    pulse_start();
    wait_xfers(400);
    #1 rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_valid", pix_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", mem_read_request, 0);
    rst = 0;
    pulse_start();
    wait_done();
    chk("replay_addr", first_addr, 0);
    chk("replay_data0", cap_d[0], 0);
    chk("replay_seq_errs", seq_errs(), 0);
    chk("replay_done_cycle", done_rel, 787);
`ifdef IMAGE_READER_CHECKSUM_EN
    for (int i = 0; i < 1024; i++) bram[i] = 8'hFF;
    fill_ff = 1;
    pulse_start();
    wait_done();
    chk("cs_seq_errs", seq_errs(), 0);
    chk("cs_value", cs_at_done, 199920);
    chk("cs_valid_at_done", cv_at_done, 1);
    #1 chk("cs_hold", checksum, 199920);
    chk("cs_valid_pulse", checksum_valid, 0);
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
